// File: rtl/addressable_io_latch.sv
// ---------------------------------------------------------------------------
// addressable_io_latch
//
// Addressable bank of DEPTH single-bit output latches on the ICU 1-bit I/O
// path. The ICU write strobe selects one bit and applies a load, set, clear,
// toggle or timed pulse operation to it. Read-back of the addressed bit feeds
// the ICU data input.
//
// Each bit owns a down-counting pulse timer. A PULSE write sets the bit and
// loads the timer with L. The bit is then dropped after exactly L cycles.
// Any other valid write to that bit cancels its timer.
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous, active-high reset
//   chip_enable  in   1        qualifies write
//   write        in   1        write strobe, sampled on rising clk
//   op           in   3        operation: 000 LOAD, 001 SET, 010 CLR,
//                              011 TOGGLE, 100 PULSE, 101..111 reserved
//   address      in   ADDR_W   bit select for write and read-back
//   data_in      in   1        data for LOAD
//   pulse_len    in   PULSE_W  pulse length in cycles (0 behaves as 1)
//   clear_all    in   1        synchronous clear of every bit and timer
//   read_data    out  1        q[address], combinational
//   q            out  DEPTH    latched output bits
//   pulse_active out  1        high while any timer is non-zero
// ---------------------------------------------------------------------------
module addressable_io_latch #(
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 2 ** ADDR_W,
    parameter int PULSE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chip_enable,
    input  logic               write,
    input  logic [2:0]         op,
    input  logic [ADDR_W-1:0]  address,
    input  logic               data_in,
    input  logic [PULSE_W-1:0] pulse_len,
    input  logic               clear_all,
    output logic               read_data,
    output logic [DEPTH-1:0]   q,
    output logic               pulse_active
);

    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_CLR    = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_PULSE  = 3'b100;

    logic               write_fire;
    logic               op_valid;
    logic [PULSE_W-1:0] pulse_load;
    logic [DEPTH-1:0]   timer_busy;

    // clear_all takes priority over a write, so the write is suppressed here.
    assign write_fire = write && chip_enable && !clear_all;

    // Reserved encodings must not touch state. Excluding them from the bit
    // hit lets a pulsing bit keep counting through a reserved write.
    assign op_valid   = (op <= OP_PULSE);

    // A zero length would never expire. It is promoted to a one-cycle pulse.
    assign pulse_load = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;

    for (genvar i = 0; i < DEPTH; i++) begin : g_bit
        logic               bit_q;
        logic [PULSE_W-1:0] timer_r;
        logic               hit;

        assign hit = write_fire && op_valid && (address == ADDR_W'(i));

        // Priority: reset > clear_all > write to this bit > timer countdown.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                bit_q   <= 1'b0;
                timer_r <= '0;
            end else if (clear_all) begin
                bit_q   <= 1'b0;
                timer_r <= '0;
            end else if (hit) begin
                // Every valid op rewrites the timer. Non-pulse ops cancel it.
                timer_r <= '0;
                case (op)
                    OP_LOAD:   bit_q <= data_in;
                    OP_SET:    bit_q <= 1'b1;
                    OP_CLR:    bit_q <= 1'b0;
                    OP_TOGGLE: bit_q <= ~bit_q;
                    OP_PULSE: begin
                        bit_q   <= 1'b1;
                        timer_r <= pulse_load;
                    end
                    default:   bit_q <= bit_q;
                endcase
            end else if (timer_r == PULSE_W'(1)) begin
                bit_q   <= 1'b0;
                timer_r <= '0;
            end else if (timer_r != '0) begin
                timer_r <= timer_r - PULSE_W'(1);
            end
        end

        assign q[i]          = bit_q;
        assign timer_busy[i] = (timer_r != '0);
    end

    assign read_data    = q[address];
    assign pulse_active = |timer_busy;

endmodule

// File: tb/tb_addressable_io_latch.sv
// ---------------------------------------------------------------------------
// tb_addressable_io_latch
//
// Table-driven single-cycle vectors cover the basic operations, gating and
// clear priority. Hand-written sequences cover pulses, retrigger, cancel,
// expiry collisions and asynchronous reset. Every step pushes its expected
// {pulse_active, read_data, q} into exp_q. That value is popped and compared
// one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_addressable_io_latch;

  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int PULSE_W = 8;
  localparam int W       = DEPTH + 2;

  localparam logic [2:0] OP_LOAD   = 3'b000;
  localparam logic [2:0] OP_SET    = 3'b001;
  localparam logic [2:0] OP_CLR    = 3'b010;
  localparam logic [2:0] OP_TOGGLE = 3'b011;
  localparam logic [2:0] OP_PULSE  = 3'b100;

  // clock/reset block
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               chip_enable = 1'b0;
  logic               write = 1'b0;
  logic [2:0]         op = '0;
  logic [ADDR_W-1:0]  address = '0;
  logic               data_in = 1'b0;
  logic [PULSE_W-1:0] pulse_len = '0;
  logic               clear_all = 1'b0;
  logic               read_data;
  logic [DEPTH-1:0]   q;
  logic               pulse_active;

  always #5 clk = ~clk;

  addressable_io_latch #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .PULSE_W(PULSE_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chip_enable(chip_enable),
    .write(write),
    .op(op),
    .address(address),
    .data_in(data_in),
    .pulse_len(pulse_len),
    .clear_all(clear_all),
    .read_data(read_data),
    .q(q),
    .pulse_active(pulse_active)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_outputs(input string name);
    logic [W-1:0] exp;
    logic [W-1:0] got;
    got = {pulse_active, read_data, q};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got=%h", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got pa=%b rd=%b q=%h, expected pa=%b rd=%b q=%h",
                 name, got[W-1], got[W-2], got[DEPTH-1:0],
                 exp[W-1], exp[W-2], exp[DEPTH-1:0]);
      end
    end
  endtask

  // driver: apply one cycle of stimulus, then compare after the edge.
  // The address is held after the edge, so read_data shows the written bit.
  task automatic step(input string name, input logic wr, input logic ce,
                      input logic clr, input logic [2:0] o,
                      input logic [ADDR_W-1:0] a, input logic d,
                      input logic [PULSE_W-1:0] len,
                      input logic [DEPTH-1:0] eq, input logic epa);
    write       = wr;
    chip_enable = ce;
    clear_all   = clr;
    op          = o;
    address     = a;
    data_in     = d;
    pulse_len   = len;
    exp_q.push_back({epa, eq[a], eq});
    @(posedge clk);
    #1;
    write     = 1'b0;
    clear_all = 1'b0;
    check_outputs(name);
  endtask

  task automatic idle(input string name, input logic [DEPTH-1:0] eq,
                      input logic epa);
    step(name, 1'b0, 1'b0, 1'b0, OP_LOAD, address, 1'b0, 8'd0, eq, epa);
  endtask

  typedef struct {
    logic              wr;
    logic              ce;
    logic              clr;
    logic [2:0]        op;
    logic [ADDR_W-1:0] a;
    logic              d;
    logic [DEPTH-1:0]  eq;
  } vec_t;

  vec_t vecs[15];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [DEPTH-1:0] m;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, OP_SET,    4'd5,  1'b0, 16'h0020};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, OP_TOGGLE, 4'd5,  1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, OP_LOAD,   4'd5,  1'b1, 16'h0020};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, OP_CLR,    4'd5,  1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, OP_SET,    4'd0,  1'b0, 16'h0001};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, OP_SET,    4'd15, 1'b0, 16'h8001};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, OP_SET,    4'd7,  1'b0, 16'h8001};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b110,    4'd0,  1'b0, 16'h8001};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b101,    4'd3,  1'b1, 16'h8001};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, OP_SET,    4'd4,  1'b0, 16'h8001};
    vecs[10] = '{1'b1, 1'b1, 1'b0, OP_LOAD,   4'd15, 1'b0, 16'h0001};
    vecs[11] = '{1'b1, 1'b1, 1'b0, OP_TOGGLE, 4'd9,  1'b0, 16'h0201};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 3'b111,    4'd9,  1'b0, 16'h0201};
    vecs[13] = '{1'b1, 1'b1, 1'b1, OP_SET,    4'd3,  1'b0, 16'h0000};
    vecs[14] = '{1'b1, 1'b1, 1'b0, OP_SET,    4'd5,  1'b0, 16'h0020};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({1'b0, 1'b0, 16'h0000});
    check_outputs("reset_held");
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b0, 1'b0, 16'h0000});
    check_outputs("after_reset");

    // Single-cycle vectors: ops, gating, reserved ops, clear_all priority
    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vecs[i].wr, vecs[i].ce, vecs[i].clr,
           vecs[i].op, vecs[i].a, vecs[i].d, 8'd0, vecs[i].eq, 1'b0);
    end

    // Pulse of length 3 on bit 2
    step("clr_before_pulse", 1'b0, 1'b0, 1'b1, OP_LOAD, 4'd2, 1'b0, 8'd0, 16'h0000, 1'b0);
    step("p3_c0", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd2, 1'b0, 8'd3, 16'h0004, 1'b1);
    idle("p3_c1", 16'h0004, 1'b1);
    idle("p3_c2", 16'h0004, 1'b1);
    idle("p3_c3", 16'h0000, 1'b0);
    idle("p3_c4", 16'h0000, 1'b0);

    // pulse_len 0 behaves as a one-cycle pulse
    step("p0_c0", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd6, 1'b0, 8'd0, 16'h0040, 1'b1);
    idle("p0_c1", 16'h0000, 1'b0);
    idle("p0_c2", 16'h0000, 1'b0);

    // Retrigger: two length-4 pulses two cycles apart give 6 cycles high
    step("rt_c0", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd1, 1'b0, 8'd4, 16'h0002, 1'b1);
    idle("rt_c1", 16'h0002, 1'b1);
    step("rt_c2", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd1, 1'b0, 8'd4, 16'h0002, 1'b1);
    idle("rt_c3", 16'h0002, 1'b1);
    idle("rt_c4", 16'h0002, 1'b1);
    idle("rt_c5", 16'h0002, 1'b1);
    idle("rt_c6", 16'h0000, 1'b0);
    idle("rt_c7", 16'h0000, 1'b0);

    // SET during a pulse cancels the timer, so the bit stays high
    step("cs_c0", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd1, 1'b0, 8'd3, 16'h0002, 1'b1);
    step("cs_set", 1'b1, 1'b1, 1'b0, OP_SET, 4'd1, 1'b0, 8'd0, 16'h0002, 1'b0);
    for (int i = 0; i < 5; i++) idle($sformatf("cs_hold%0d", i), 16'h0002, 1'b0);
    step("cs_clr", 1'b0, 1'b0, 1'b1, OP_LOAD, 4'd1, 1'b0, 8'd0, 16'h0000, 1'b0);

    // Write on the expiry cycle wins; bit 7 expires on the same edge
    step("ex_p3", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd3, 1'b0, 8'd2, 16'h0008, 1'b1);
    step("ex_p7", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd7, 1'b0, 8'd1, 16'h0088, 1'b1);
    step("ex_load", 1'b1, 1'b1, 1'b0, OP_LOAD, 4'd3, 1'b1, 8'd0, 16'h0008, 1'b0);
    idle("ex_hold0", 16'h0008, 1'b0);
    idle("ex_hold1", 16'h0008, 1'b0);

    // clear_all aborts a running pulse and beats a concurrent PULSE write
    step("ca_p8", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd8, 1'b0, 8'd5, 16'h0108, 1'b1);
    step("ca_clr", 1'b1, 1'b1, 1'b1, OP_PULSE, 4'd9, 1'b0, 8'd4, 16'h0000, 1'b0);
    idle("ca_after", 16'h0000, 1'b0);

    // TOGGLE cancels a pulse; a reserved op does not
    step("tg_p10", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd10, 1'b0, 8'd5, 16'h0400, 1'b1);
    step("tg_tog", 1'b1, 1'b1, 1'b0, OP_TOGGLE, 4'd10, 1'b0, 8'd0, 16'h0000, 1'b0);
    idle("tg_after", 16'h0000, 1'b0);
    step("rs_p11", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd11, 1'b0, 8'd2, 16'h0800, 1'b1);
    step("rs_res", 1'b1, 1'b1, 1'b0, 3'b111, 4'd11, 1'b0, 8'd9, 16'h0800, 1'b1);
    idle("rs_exp", 16'h0000, 1'b0);

    // Fill all bits, start a pulse, then reset asynchronously mid-cycle
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = 1'b1;
      step($sformatf("fill%0d", i), 1'b1, 1'b1, 1'b0, OP_SET, ADDR_W'(i),
           1'b0, 8'd0, m, 1'b0);
    end
    step("fill_pulse", 1'b1, 1'b1, 1'b0, OP_PULSE, 4'd0, 1'b0, 8'd9, 16'hffff, 1'b1);
    address = 4'd12;
    #3;
    reset = 1'b1;
    #1;
    exp_q.push_back({1'b0, 1'b0, 16'h0000});
    check_outputs("async_reset");
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle($sformatf("post_reset%0d", i), 16'h0000, 1'b0);

    // Randomised single-bit SET/readback on a cleared bank
    for (int i = 0; i < 4; i++) begin
      logic [ADDR_W-1:0] ra;
      ra = ADDR_W'($urandom_range(0, DEPTH - 1));
      m = '0;
      m[ra] = 1'b1;
      step($sformatf("rnd_set%0d", i), 1'b1, 1'b1, 1'b0, OP_SET, ra, 1'b0, 8'd0, m, 1'b0);
      step($sformatf("rnd_clr%0d", i), 1'b1, 1'b1, 1'b0, OP_CLR, ra, 1'b0, 8'd0, 16'h0000, 1'b0);
    end

    // final report
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
